// File: rtl/ulpi_rx_link.sv
// ULPI receive link on the oversampling system clock.
// Detects ulpi_clk rising edges, follows bus turnaround, captures RX CMD
// bytes and frames received data into packets buffered in a small FIFO.
//
// state     | meaning
// ----------+-----------------------------------------------
// IDLE      | link owns the bus, nothing being received
// TURN_UP   | PHY took the bus, turnaround cycle
// RX_CMD    | PHY owns the bus, between packets
// RX_DATA   | packet in progress, data bytes on nxt=1
// TURN_DOWN | PHY released the bus, turnaround back to link
module ulpi_rx_link #(
  parameter int         FIFO_DEPTH   = 16,
  parameter int         CNT_W        = 11,
  parameter logic [1:0] RXCMD_ACTIVE = 2'b01,
  parameter logic [1:0] RXCMD_ERROR  = 2'b11
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             ulpi_clk,
  input  logic             dir,
  input  logic             nxt,
  input  logic [7:0]       data_in,
  input  logic             rx_ready,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  output logic [7:0]       rxcmd,
  output logic             rxcmd_update,
  output logic [1:0]       linestate,
  output logic             pkt_done,
  output logic [CNT_W-1:0] pkt_len,
  output logic [2:0]       pkt_status,
  output logic             busy
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    TURN_UP,
    RX_CMD,
    RX_DATA,
    TURN_DOWN
  } state_t;

  state_t           state;
  logic             uclk_s1;
  logic             uclk_s2;
  logic             dir_r;
  logic             nxt_r;
  logic [7:0]       data_r;
  logic             edge_e;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [2:0]       status;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             fifo_empty;
  logic             fifo_full;
  logic             push_req;
  logic             push_ok;
  logic             drop;
  logic             pop;

  // Synchronise ulpi_clk and register the bus alongside it
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      uclk_s1 <= 1'b0;
      uclk_s2 <= 1'b0;
      dir_r   <= 1'b0;
      nxt_r   <= 1'b0;
      data_r  <= 8'h00;
    end else begin
      uclk_s1 <= ulpi_clk;
      uclk_s2 <= uclk_s1;
      dir_r   <= dir;
      nxt_r   <= nxt;
      data_r  <= data_in;
    end
  end

  assign edge_e = uclk_s1 & ~uclk_s2;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rx_valid   = ~fifo_empty;
  assign rx_data    = fifo_empty ? 8'h00 : mem[rd_ptr[AW-1:0]];
  assign pop        = rx_valid & rx_ready;

  // A data byte arrives whenever the PHY drives nxt while receiving; a byte in
  // RX_CMD with nxt=1 is the first byte of a packet that began without RxActive.
  assign push_req = edge_e & dir_r & nxt_r & ((state == RX_DATA) || (state == RX_CMD));
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push_ok  = push_req & (~fifo_full | pop);
  assign drop     = push_req & ~push_ok;

  assign cnt_inc   = (&cnt) ? cnt : cnt + CNT_W'(1);
  assign linestate = rxcmd[1:0];
  assign busy      = (state != IDLE);

  // Payload FIFO write/read pointers and storage
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr[AW-1:0]] <= data_r;
        wr_ptr              <= wr_ptr + (AW+1)'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
    end
  end

  // Receive state machine, packet accounting and registered status outputs
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state        <= IDLE;
      cnt          <= '0;
      status       <= 3'b000;
      rxcmd        <= 8'h00;
      rxcmd_update <= 1'b0;
      pkt_done     <= 1'b0;
      pkt_len      <= '0;
      pkt_status   <= 3'b000;
    end else begin
      rxcmd_update <= 1'b0;
      pkt_done     <= 1'b0;
      if (edge_e) begin
        case (state)
          IDLE: begin
            if (dir_r) state <= TURN_UP;
          end
          TURN_UP: begin
            if (!dir_r) begin
              state <= IDLE;
            end else if (nxt_r) begin
              state  <= RX_DATA;
              cnt    <= '0;
              status <= 3'b000;
            end else begin
              state <= RX_CMD;
            end
          end
          RX_CMD: begin
            if (!dir_r) begin
              state <= TURN_DOWN;
            end else if (!nxt_r) begin
              rxcmd        <= data_r;
              rxcmd_update <= 1'b1;
              if (data_r[5:4] == RXCMD_ACTIVE) begin
                state  <= RX_DATA;
                cnt    <= '0;
                status <= 3'b000;
              end
            end else begin
              // Packet starts with this byte already on the wire
              state  <= RX_DATA;
              cnt    <= CNT_W'(1);
              status <= {drop, 2'b00};
            end
          end
          RX_DATA: begin
            if (!dir_r) begin
              state      <= TURN_DOWN;
              status     <= status | 3'b001;
              pkt_done   <= 1'b1;
              pkt_len    <= cnt;
              pkt_status <= status | 3'b001;
            end else if (nxt_r) begin
              cnt <= cnt_inc;
              if (drop) status[2] <= 1'b1;
            end else begin
              rxcmd        <= data_r;
              rxcmd_update <= 1'b1;
              if (data_r[5:4] == RXCMD_ERROR) begin
                status[1] <= 1'b1;
              end else if (data_r[5:4] != RXCMD_ACTIVE) begin
                state      <= RX_CMD;
                pkt_done   <= 1'b1;
                pkt_len    <= cnt;
                pkt_status <= status;
              end
            end
          end
          TURN_DOWN: begin
            state <= dir_r ? TURN_UP : IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ulpi_rx_link.sv
// Directed testbench for ulpi_rx_link: drives ULPI cycles on a slow ulpi_clk
// (4 system clocks per PHY cycle) and checks packets, RX CMDs and the FIFO.
module tb_ulpi_rx_link;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        ulpi_clk = 1'b0;
  logic        dir = 1'b0;
  logic        nxt = 1'b0;
  logic [7:0]  data_in = 8'h00;
  logic        rx_ready = 1'b0;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  rxcmd;
  logic        rxcmd_update;
  logic [1:0]  linestate;
  logic        pkt_done;
  logic [10:0] pkt_len;
  logic [2:0]  pkt_status;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int upd_cnt = 0;

  ulpi_rx_link #(
    .FIFO_DEPTH(16),
    .CNT_W(11),
    .RXCMD_ACTIVE(2'b01),
    .RXCMD_ERROR(2'b11)
  ) dut (
    .clk(clk),
    .n_rst(n_rst),
    .ulpi_clk(ulpi_clk),
    .dir(dir),
    .nxt(nxt),
    .data_in(data_in),
    .rx_ready(rx_ready),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rxcmd(rxcmd),
    .rxcmd_update(rxcmd_update),
    .linestate(linestate),
    .pkt_done(pkt_done),
    .pkt_len(pkt_len),
    .pkt_status(pkt_status),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Count output pulses on the active edge so negedge reads never race
  always @(posedge clk) begin
    if (pkt_done) done_cnt++;
    if (rxcmd_update) upd_cnt++;
  end

  // One PHY cycle; returns on the negedge after the edge that acts on it.
  // pop_e raises rx_ready for exactly the clk cycle in which the push lands.
  task automatic ucyc(input logic d, input logic n, input logic [7:0] x, input bit pop_e);
    ulpi_clk = 1'b0;
    dir = d;
    nxt = n;
    data_in = x;
    @(negedge clk);
    @(negedge clk);
    ulpi_clk = 1'b1;
    @(negedge clk);
    if (pop_e) rx_ready = 1'b1;
    @(negedge clk);
    if (pop_e) rx_ready = 1'b0;
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({rx_valid, rx_data, rxcmd, rxcmd_update, linestate, pkt_done, pkt_len, pkt_status, busy} !== 36'h0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b data=%h rxcmd=%h upd=%b ls=%b done=%b len=%0d st=%b busy=%b, want all 0",
               rx_valid, rx_data, rxcmd, rxcmd_update, linestate, pkt_done, pkt_len, pkt_status, busy);
    end
    n_rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_packet();
    logic [7:0] exp [3] = '{8'hA5, 8'h3C, 8'h0F};
    int d0 = done_cnt;
    ucyc(1, 0, 8'h00, 0);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_turnup: got %b want 1", busy); end
    ucyc(1, 1, 8'h00, 0);
    ucyc(1, 1, 8'hA5, 0);
    checks++;
    if (rx_valid !== 1'b1 || rx_data !== 8'hA5) begin
      errors++; $display("FAIL single_first_word: got valid=%b data=%h want 1/a5", rx_valid, rx_data);
    end
    ucyc(1, 1, 8'h3C, 0);
    ucyc(1, 1, 8'h0F, 0);
    ucyc(1, 0, 8'h00, 0);
    checks++;
    if (pkt_done !== 1'b1 || pkt_len !== 11'd3 || pkt_status !== 3'b000) begin
      errors++; $display("FAIL single_pkt_end: got done=%b len=%0d st=%b want 1/3/000", pkt_done, pkt_len, pkt_status);
    end
    @(negedge clk);
    checks++;
    if (pkt_done !== 1'b0 || pkt_len !== 11'd3 || busy !== 1'b1) begin
      errors++; $display("FAIL single_after_end: got done=%b len=%0d busy=%b want 0/3/1", pkt_done, pkt_len, busy);
    end
    ucyc(0, 0, 8'h00, 0);
    ucyc(0, 0, 8'h00, 0);
    checks++;
    if (busy !== 1'b0 || done_cnt !== d0 + 1) begin
      errors++; $display("FAIL single_idle: got busy=%b pulses=%0d want 0/%0d", busy, done_cnt - d0, 1);
    end
    rx_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rx_valid !== 1'b1 || rx_data !== exp[i]) begin
        errors++; $display("FAIL single_drain[%0d]: got valid=%b data=%h want 1/%h", i, rx_valid, rx_data, exp[i]);
      end
      @(negedge clk);
    end
    rx_ready = 1'b0;
    checks++;
    if (rx_valid !== 1'b0) begin errors++; $display("FAIL single_empty: got valid=%b want 0", rx_valid); end
  endtask

  task automatic test_rxcmd_start();
    int u0 = upd_cnt;
    ucyc(1, 0, 8'h00, 0);
    ucyc(1, 0, 8'h00, 0);
    ucyc(1, 0, 8'h1D, 0);
    checks++;
    if (rxcmd !== 8'h1D || linestate !== 2'b01) begin
      errors++; $display("FAIL rxcmd_load: got rxcmd=%h ls=%b want 1d/01", rxcmd, linestate);
    end
    ucyc(1, 1, 8'hB1, 0);
    ucyc(1, 1, 8'hB2, 0);
    ucyc(0, 0, 8'h00, 0);
    checks++;
    if (pkt_done !== 1'b1 || pkt_len !== 11'd2 || pkt_status !== 3'b001) begin
      errors++; $display("FAIL rxcmd_trunc_end: got done=%b len=%0d st=%b want 1/2/001", pkt_done, pkt_len, pkt_status);
    end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL rxcmd_turn_down: got busy=%b want 1", busy); end
    ucyc(0, 0, 8'h00, 0);
    checks++;
    if (busy !== 1'b0 || upd_cnt !== u0 + 1) begin
      errors++; $display("FAIL rxcmd_idle: got busy=%b updates=%0d want 0/1", busy, upd_cnt - u0);
    end
    rx_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (rx_valid !== 1'b1 || rx_data !== (i == 0 ? 8'hB1 : 8'hB2)) begin
        errors++; $display("FAIL rxcmd_drain[%0d]: got valid=%b data=%h", i, rx_valid, rx_data);
      end
      @(negedge clk);
    end
    rx_ready = 1'b0;
  endtask

  task automatic test_error();
    ucyc(1, 0, 8'h00, 0);
    ucyc(1, 1, 8'h00, 0);
    ucyc(1, 1, 8'h11, 0);
    ucyc(1, 1, 8'h22, 0);
    ucyc(1, 0, 8'h30, 0);
    checks++;
    if (pkt_done !== 1'b0 || busy !== 1'b1 || rxcmd !== 8'h30) begin
      errors++; $display("FAIL error_cmd: got done=%b busy=%b rxcmd=%h want 0/1/30", pkt_done, busy, rxcmd);
    end
    ucyc(1, 1, 8'h33, 0);
    ucyc(1, 0, 8'h00, 0);
    checks++;
    if (pkt_done !== 1'b1 || pkt_len !== 11'd3 || pkt_status !== 3'b010) begin
      errors++; $display("FAIL error_end: got done=%b len=%0d st=%b want 1/3/010", pkt_done, pkt_len, pkt_status);
    end
    ucyc(0, 0, 8'h00, 0);
    ucyc(0, 0, 8'h00, 0);
    rx_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rx_valid !== 1'b1 || rx_data !== 8'(8'h11 * (i + 1))) begin
        errors++; $display("FAIL error_drain[%0d]: got valid=%b data=%h want 1/%h", i, rx_valid, rx_data, 8'(8'h11 * (i + 1)));
      end
      @(negedge clk);
    end
    rx_ready = 1'b0;
  endtask

  task automatic test_overflow();
    ucyc(1, 0, 8'h00, 0);
    ucyc(1, 1, 8'h00, 0);
    for (int i = 0; i < 20; i++) ucyc(1, 1, 8'(8'h40 + i), 0);
    ucyc(1, 0, 8'h00, 0);
    checks++;
    if (pkt_done !== 1'b1 || pkt_len !== 11'd20 || pkt_status !== 3'b100) begin
      errors++; $display("FAIL ovf_end: got done=%b len=%0d st=%b want 1/20/100", pkt_done, pkt_len, pkt_status);
    end
    ucyc(0, 0, 8'h00, 0);
    ucyc(0, 0, 8'h00, 0);
    rx_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (rx_valid !== 1'b1 || rx_data !== 8'(8'h40 + i)) begin
        errors++; $display("FAIL ovf_drain[%0d]: got valid=%b data=%h want 1/%h", i, rx_valid, rx_data, 8'(8'h40 + i));
      end
      @(negedge clk);
    end
    rx_ready = 1'b0;
    checks++;
    if (rx_valid !== 1'b0) begin errors++; $display("FAIL ovf_count: got valid=%b after 16 pops want 0", rx_valid); end
  endtask

  task automatic test_full_push_pop();
    ucyc(1, 0, 8'h00, 0);
    ucyc(1, 1, 8'h00, 0);
    for (int i = 0; i < 16; i++) ucyc(1, 1, 8'(8'h80 + i), 0);
    ucyc(1, 1, 8'h90, 1);
    ucyc(1, 0, 8'h00, 0);
    checks++;
    if (pkt_done !== 1'b1 || pkt_len !== 11'd17 || pkt_status !== 3'b000) begin
      errors++; $display("FAIL full_pp_end: got done=%b len=%0d st=%b want 1/17/000", pkt_done, pkt_len, pkt_status);
    end
    ucyc(0, 0, 8'h00, 0);
    ucyc(0, 0, 8'h00, 0);
    rx_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (rx_valid !== 1'b1 || rx_data !== 8'(8'h81 + i)) begin
        errors++; $display("FAIL full_pp_drain[%0d]: got valid=%b data=%h want 1/%h", i, rx_valid, rx_data, 8'(8'h81 + i));
      end
      @(negedge clk);
    end
    rx_ready = 1'b0;
    checks++;
    if (rx_valid !== 1'b0) begin errors++; $display("FAIL full_pp_count: got valid=%b after 16 pops want 0", rx_valid); end
  endtask

  task automatic test_reset_mid_packet();
    int d0;
    ucyc(1, 0, 8'h00, 0);
    ucyc(1, 1, 8'h00, 0);
    for (int i = 0; i < 5; i++) ucyc(1, 1, 8'(8'h60 + i), 0);
    d0 = done_cnt;
    n_rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({rx_valid, rx_data, rxcmd, rxcmd_update, linestate, pkt_done, pkt_len, pkt_status, busy} !== 36'h0) begin
      errors++;
      $display("FAIL midrst_outputs: got valid=%b data=%h rxcmd=%h done=%b len=%0d st=%b busy=%b, want all 0",
               rx_valid, rx_data, rxcmd, pkt_done, pkt_len, pkt_status, busy);
    end
    ulpi_clk = 1'b0;
    dir = 1'b0;
    nxt = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (done_cnt !== d0 || busy !== 1'b0) begin
      errors++; $display("FAIL midrst_no_done: got pulses=%0d busy=%b want 0/0", done_cnt - d0, busy);
    end
    ucyc(1, 0, 8'h00, 0);
    ucyc(1, 1, 8'h00, 0);
    ucyc(1, 1, 8'h77, 0);
    ucyc(1, 0, 8'h00, 0);
    checks++;
    if (pkt_done !== 1'b1 || pkt_len !== 11'd1 || pkt_status !== 3'b000) begin
      errors++; $display("FAIL midrst_next_pkt: got done=%b len=%0d st=%b want 1/1/000", pkt_done, pkt_len, pkt_status);
    end
    checks++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h77) begin
      errors++; $display("FAIL midrst_fifo: got valid=%b data=%h want 1/77", rx_valid, rx_data);
    end
    ucyc(0, 0, 8'h00, 0);
    ucyc(0, 0, 8'h00, 0);
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_rxcmd_start();
    test_error();
    test_overflow();
    test_full_push_pop();
    test_reset_mid_packet();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/ulpi_rx_link.md
Name: ulpi_rx_link

Overview:
Parametrised ULPI receive link for the USB datapath, running on the oversampling system clock clk. It detects ulpi_clk edges internally, tracks bus turnaround, decodes RX CMD bytes, and frames received data bytes into packets. Payload is buffered in an internal FIFO with a valid/ready output. Per-packet length and status are reported alongside, and the latest RX CMD is exported to the protocol layer.

Parameters:
FIFO_DEPTH, 16, payload FIFO entries; power of two, minimum 2.
CNT_W, 11, width of the packet byte counter; saturates at all-ones.
RXCMD_ACTIVE, 2'b01, value of RX CMD[5:4] meaning RxActive.
RXCMD_ERROR, 2'b11, value of RX CMD[5:4] meaning RxError.

Ports:
clk  in  1  system clock, at least 4x ulpi_clk
n_rst  in  1  asynchronous active-low reset
ulpi_clk  in  1  PHY clock, sampled by clk
dir  in  1  ULPI dir
nxt  in  1  ULPI nxt
data_in  in  8  ULPI data bus
rx_ready  in  1  consumer accepts rx_data this clk cycle
rx_data  out  8  FIFO head byte
rx_valid  out  1  FIFO non-empty
rxcmd  out  8  last RX CMD byte captured
rxcmd_update  out  1  one-clk pulse when rxcmd is loaded
linestate  out  2  rxcmd[1:0]
pkt_done  out  1  one-clk pulse at packet end
pkt_len  out  CNT_W  byte count of the finished packet; valid while pkt_done is high, held afterwards
pkt_status  out  3  {overflow, rx_error, truncated}; valid with pkt_done
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: state IDLE, FIFO empty, rx_valid=0, rx_data=0, rxcmd=0, rxcmd_update=0, linestate=0, pkt_done=0, pkt_len=0, pkt_status=0, busy=0. Counters and status are cleared. Reset mid-packet discards the packet and emits no pkt_done.
- Sampling: ulpi_clk is registered through two stages. A ULPI edge event (E) fires for one clk cycle when the older stage is 0 and the newer stage is 1. dir, nxt and data_in are registered on the same clk cycle. All protocol decisions use these registered copies, only in cycles where E=1.
- State machine (transitions occur only on E):
  - IDLE:
    - dir=1 -> TURN_UP.
  - TURN_UP (turnaround; data ignored):
    - dir=0 -> IDLE.
    - nxt=1 -> RX_DATA; this is a packet start and the byte counter is cleared.
    - else -> RX_CMD.
  - RX_CMD:
    - dir=0 -> TURN_DOWN.
    - nxt=0: load rxcmd and pulse rxcmd_update. If [5:4]=RXCMD_ACTIVE -> RX_DATA (packet start, counter cleared). Otherwise stay.
    - nxt=1 -> RX_DATA (packet start); the byte is pushed as data.
  - RX_DATA:
    - nxt=1, dir=1: push data_in and increment the counter (saturating).
    - nxt=0, dir=1: load rxcmd and pulse rxcmd_update. If [5:4]=RXCMD_ERROR, set rx_error. If [5:4] is neither ACTIVE nor ERROR, end the packet -> RX_CMD.
    - dir=0: end the packet with truncated=1 -> TURN_DOWN.
  - TURN_DOWN:
    - Next E -> IDLE. If dir=1 on that E -> TURN_UP.
- Packet end: pkt_done pulses in the clk cycle after the E that ends the packet. pkt_len and pkt_status are driven in that same cycle. The status bits are sticky within a packet and cleared at packet start.
- FIFO:
  - Push is accepted if not full, or if full with rx_valid and rx_ready in the same cycle.
  - Otherwise the byte is dropped, overflow is set, and the counter still increments, so pkt_len reflects bytes on the wire.
  - Pop occurs when rx_valid & rx_ready. Pop from empty has no effect.
  - Read and write pointers wrap modulo FIFO_DEPTH.
  - A pushed byte appears at rx_data no earlier than one clk after the push; first-word latency is 1 clk.
- Ordering: a packet's last byte is pushed no later than its pkt_done pulse. pkt_done does not wait for the FIFO to drain.
- busy equals (state != IDLE).

Test Plan:
- Single packet: dir rises, turnaround with nxt=1, then data 0xA5, 0x3C, 0x0F with nxt=1, then RX CMD 0x00 with nxt=0 -> FIFO yields A5, 3C, 0F in order; pkt_done with pkt_len=3 and pkt_status=000; state RX_CMD.
- RX CMD start: turnaround with nxt=0, RX CMD 0x1D, two bytes, then dir falls -> rxcmd=0x1D, linestate=01, rxcmd_update pulses once; pkt_len=2, pkt_status=001; IDLE two E later.
- Error mid-packet: bytes 0x11, 0x22, RX CMD 0x30, byte 0x33, RX CMD 0x00 -> pkt_len=3, pkt_status=010.
- Overflow: FIFO_DEPTH=16, rx_ready=0, 20 data bytes -> exactly 16 stored (first 16); pkt_len=20, status=100. Then rx_ready=1 drains the 16 bytes in order.
- Full with simultaneous push and pop: FIFO full, rx_ready=1 on the push cycle -> no overflow; count stays 16.
- Reset mid-packet: assert n_rst after 5 bytes -> all outputs return to reset values, no pkt_done. A subsequent 1-byte packet reports pkt_len=1.
